pat_stream_unpacker: RTL
========================

Name: pat_stream_unpacker

Overview:
- Downstream neighbour of the DDR2 pattern store/fetch stage, in the camera clock domain.
- Pops 64-bit pattern words from the read side of the output FIFO that the memory stage fills.
- Unpacks each word into four 16-bit channel slices, tags each slice with row, column and pattern index, and streams them to the pixel-mask driver under valid/ready.
- Requests memory reads (read_start) whenever the FIFO runs dry during a frame. A frame is num_pat + 2 patterns: start, user patterns, last.

Parameters:
- ROWS, 18, rows per pattern
- COLS, 160, 16-bit slices per row
- SLICES_PER_WORD, 4, 16-bit slices per 64-bit FIFO word (fixed by the 64-bit FIFO width)
- WORDS_PER_PAT, ROWS*COLS/SLICES_PER_WORD = 720, FIFO words per pattern

Ports:
- cam_clk, in, 1: sole clock
- cam_rst_n, in, 1: synchronous, active-low reset
- frame_start, in, 1: one-cycle pulse; begin a frame
- num_pat, in, 32: user pattern count; sampled on an accepted frame_start
- outfifo_dout, in, 64: FIFO read data; valid one cycle after outfifo_rd_en
- outfifo_empty, in, 1: FIFO empty flag
- outfifo_rd_en, out, 1: FIFO pop
- read_start, out, 1: level request to the memory stage for another burst
- pat_data, out, 16: channel slice
- pat_row, out, 5: 0..17
- pat_col, out, 8: 0..159
- pat_idx, out, 32: 0..num_pat+1
- pat_first, out, 1: pat_idx == 0
- pat_last, out, 1: pat_idx == num_pat+1
- pat_valid, out, 1: slice valid
- pat_ready, in, 1: consumer accepts
- busy, out, 1: frame in progress
- frame_done, out, 1: one-cycle pulse after the final slice is accepted

Behaviour:
- Reset (cam_rst_n low at a cam_clk edge): all outputs 0, state IDLE, counters 0, latched num_pat 0. Reset mid-frame aborts immediately; FIFO contents are not drained.
- IDLE:
  - frame_start latches total = num_pat + 2 (33-bit; num_pat = 0xFFFFFFFF does not wrap).
  - Sets busy = 1, goes to FETCH.
  - frame_start while busy is ignored.
- FETCH:
  - If !outfifo_empty: outfifo_rd_en = 1 for exactly one cycle, go to LOAD.
  - Otherwise hold with read_start = 1.
  - read_start is registered, high only while in FETCH with outfifo_empty, and drops the cycle after empty deasserts.
- LOAD: capture outfifo_dout into a 64-bit holding register, slice = 0, go to SHIFT.
- SHIFT:
  - pat_valid = 1, pat_data = hold[16*slice+15 : 16*slice]; bits [15:0] go first.
  - On pat_valid & pat_ready, advance col; at col 159 wrap col to 0 and increment row.
  - Also on each accept, increment slice; at slice 3 the next state is FETCH.
  - At row 17 / col 159 accepted, wrap row to 0 and increment pat_idx.
  - If that was the last slice of pattern total-1, go to DONE instead.
  - All outputs stay stable while pat_ready is low.
- DONE: frame_done = 1 for one cycle, busy = 0, pat_idx/row/col cleared, return to IDLE.
- Throughput: a new word is fetched after every 4 accepted slices. With the FIFO non-empty and pat_ready high, each word costs 4 SHIFT + 1 FETCH + 1 LOAD = 6 cycles; no prefetch.
- Latency: frame_start to first pat_valid is 3 cycles when the FIFO is non-empty.
- Only one FIFO read is ever outstanding, so no overflow of the holding register is possible.
- Empty FIFO mid-pattern: stall in FETCH with pat_valid low; row/col/pat_idx are preserved.
- pat_first / pat_last are combinational from pat_idx and total, and are meaningful only when pat_valid is high.
- Widths: slice 2b, col 8b, row 5b, pat_idx 32b with compare against 33b total.

Decomposition:
- Package pat_stream_pkg: ROWS, COLS, SLICES_PER_WORD, WORDS_PER_PAT; state enum {IDLE, FETCH, LOAD, SHIFT, DONE}.
- Sub-module pat_coord_cnt: slice/col/row/pat_idx counters with enable = accept and wrap/terminal outputs; instantiated once.
- The FSM and holding register stay in the top.

Test Plan:
- Reset: drive cam_rst_n low for 2 cycles mid-SHIFT -> next cycle all outputs 0, busy 0; a subsequent frame_start restarts from pat_idx 0, row 0, col 0.
- Single-word order: FIFO holds 0x4444_3333_2222_1111, pat_ready held high -> pat_data sequence 0x1111, 0x2222, 0x3333, 0x4444 at cols 0..3, row 0, then outfifo_rd_en for the next word.
- Full frame, num_pat = 1: 3*720 = 2160 words preloaded -> exactly 8640 accepts; pat_first only on idx 0, pat_last only on idx 2; row wraps at col 159, 17; single frame_done pulse; busy low after.
- Starvation: FIFO empties after 10 words -> read_start rises the cycle after entering FETCH, pat_valid 0, coordinates held at row 0, col 40; refill -> resumes at col 40 with read_start low.
- Backpressure: random pat_ready at 30% duty -> data/row/col stable while not ready; no slice lost or duplicated versus a scoreboard.
- Spurious frame_start mid-frame and num_pat = 0 -> the pulse is ignored; the num_pat = 0 frame yields exactly 2 patterns (5760 accepts).

Source files
------------

// File: rtl/pat_stream_pkg.sv
// Shared geometry, counter widths and FSM state encoding for the pattern
// stream unpacker.
package pat_stream_pkg;

    localparam int ROWS            = 18;
    localparam int COLS            = 160;
    localparam int SLICES_PER_WORD = 4;
    localparam int WORDS_PER_PAT   = ROWS * COLS / SLICES_PER_WORD;

    localparam int SLICE_W = 2;
    localparam int COL_W   = 8;
    localparam int ROW_W   = 5;
    localparam int IDX_W   = 32;
    localparam int TOTAL_W = 33;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Pick one 16-bit channel slice out of a 64-bit FIFO word; slice 0 is
    // the least significant half-word and leaves the block first.
    function automatic logic [15:0] slice_of(input logic [63:0]        word,
                                             input logic [SLICE_W-1:0] sel);
        logic [15:0] v;
        v = word[15:0];
        case (sel)
            2'd0:    v = word[15:0];
            2'd1:    v = word[31:16];
            2'd2:    v = word[47:32];
            default: v = word[63:48];
        endcase
        return v;
    endfunction

endpackage

// File: rtl/pat_coord_cnt.sv
// Slice / column / row / pattern-index counters for the unpacked stream.
// Everything advances on one enable (a consumer accept); i_clr rewinds all
// counters to the start of a frame and takes priority over the enable.
module pat_coord_cnt
    import pat_stream_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_clr,
    output logic [SLICE_W-1:0] o_slice,
    output logic [COL_W-1:0]   o_col,
    output logic [ROW_W-1:0]   o_row,
    output logic [IDX_W-1:0]   o_pat_idx,
    output logic               o_word_end,
    output logic               o_pat_end
);

    logic [SLICE_W-1:0] r_slice;
    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;
    logic [IDX_W-1:0]   r_pat_idx;

    logic w_col_end;
    logic w_row_end;

    assign w_col_end  = (r_col == COL_W'(COLS - 1));
    assign w_row_end  = (r_row == ROW_W'(ROWS - 1));

    // Slice 3 closes a word; because COLS is a multiple of four this also
    // lines up with every row boundary.
    assign o_word_end = (r_slice == SLICE_W'(SLICES_PER_WORD - 1));
    assign o_pat_end  = w_col_end & w_row_end;

    assign o_slice    = r_slice;
    assign o_col      = r_col;
    assign o_row      = r_row;
    assign o_pat_idx  = r_pat_idx;

    // Nested wrap: slice every accept, col -> row -> pattern index on wrap.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_slice   <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_pat_idx <= '0;
        end else if (i_en) begin
            r_slice <= r_slice + SLICE_W'(1);
            if (w_col_end) begin
                r_col <= '0;
                if (w_row_end) begin
                    r_row     <= '0;
                    r_pat_idx <= r_pat_idx + IDX_W'(1);
                end else begin
                    r_row <= r_row + ROW_W'(1);
                end
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/pat_stream_unpacker.sv
// Pops 64-bit pattern words from the memory-stage output FIFO and streams
// them to the pixel-mask driver as tagged 16-bit slices.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for frame_start; latches the pattern total
//   FETCH | pop one word when the FIFO has data, else ask memory for more
//   LOAD  | FIFO read data is valid; capture it into the holding register
//   SHIFT | present slices 0..3 of the held word under valid/ready
//   DONE  | one-cycle frame_done pulse, then back to IDLE
module pat_stream_unpacker
    import pat_stream_pkg::*;
(
    input  logic        cam_clk,
    input  logic        cam_rst_n,
    input  logic        frame_start,
    input  logic [31:0] num_pat,
    input  logic [63:0] outfifo_dout,
    input  logic        outfifo_empty,
    output logic        outfifo_rd_en,
    output logic        read_start,
    output logic [15:0] pat_data,
    output logic [4:0]  pat_row,
    output logic [7:0]  pat_col,
    output logic [31:0] pat_idx,
    output logic        pat_first,
    output logic        pat_last,
    output logic        pat_valid,
    input  logic        pat_ready,
    output logic        busy,
    output logic        frame_done
);

    state_t             r_state;
    state_t             w_next_state;
    logic [63:0]        r_hold;
    logic [TOTAL_W-1:0] r_total;
    logic               r_read_start;

    logic [SLICE_W-1:0] w_slice;
    logic [COL_W-1:0]   w_col;
    logic [ROW_W-1:0]   w_row;
    logic [IDX_W-1:0]   w_pat_idx;
    logic               w_word_end;
    logic               w_pat_end;
    logic               w_accept;
    logic               w_final_pat;
    logic               w_final_slice;
    logic               w_frame_go;

    // Total is 33 bits so num_pat = all-ones still yields a correct count;
    // after reset total is 0 and total-1 is all-ones, so nothing matches.
    assign w_final_pat   = ({1'b0, w_pat_idx} == (r_total - TOTAL_W'(1)));
    assign w_final_slice = w_pat_end & w_final_pat;
    assign w_accept      = pat_valid & pat_ready;
    assign w_frame_go    = (r_state == IDLE) & frame_start;

    pat_coord_cnt u_coord (
        .i_clk      (cam_clk),
        .i_rst_n    (cam_rst_n),
        .i_en       (w_accept),
        .i_clr      (w_accept & w_final_slice),
        .o_slice    (w_slice),
        .o_col      (w_col),
        .o_row      (w_row),
        .o_pat_idx  (w_pat_idx),
        .o_word_end (w_word_end),
        .o_pat_end  (w_pat_end)
    );

    // State register.
    always_ff @(posedge cam_clk) begin
        if (!cam_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-state outputs; one outstanding FIFO read at most.
    always_comb begin
        w_next_state  = r_state;
        outfifo_rd_en = 1'b0;
        pat_valid     = 1'b0;
        busy          = 1'b0;
        frame_done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (frame_start) begin
                    w_next_state = FETCH;
                end
            end
            FETCH: begin
                busy = 1'b1;
                if (!outfifo_empty) begin
                    outfifo_rd_en = 1'b1;
                    w_next_state  = LOAD;
                end
            end
            LOAD: begin
                busy         = 1'b1;
                w_next_state = SHIFT;
            end
            SHIFT: begin
                busy      = 1'b1;
                pat_valid = 1'b1;
                if (pat_ready) begin
                    if (w_final_slice) begin
                        w_next_state = DONE;
                    end else if (w_word_end) begin
                        w_next_state = FETCH;
                    end
                end
            end
            DONE: begin
                frame_done   = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Pattern total for the frame, captured only when a frame is accepted.
    always_ff @(posedge cam_clk) begin
        if (!cam_rst_n) begin
            r_total <= '0;
        end else if (w_frame_go) begin
            r_total <= {1'b0, num_pat} + TOTAL_W'(2);
        end
    end

    // Holding register: FIFO data arrives the cycle after the pop.
    always_ff @(posedge cam_clk) begin
        if (!cam_rst_n) begin
            r_hold <= '0;
        end else if (r_state == LOAD) begin
            r_hold <= outfifo_dout;
        end
    end

    // Burst request to the memory stage while starved in FETCH.
    always_ff @(posedge cam_clk) begin
        if (!cam_rst_n) begin
            r_read_start <= 1'b0;
        end else begin
            r_read_start <= (r_state == FETCH) & outfifo_empty;
        end
    end

    assign read_start = r_read_start;
    assign pat_data   = slice_of(r_hold, w_slice);
    assign pat_row    = w_row;
    assign pat_col    = w_col;
    assign pat_idx    = w_pat_idx;
    assign pat_first  = pat_valid & (w_pat_idx == '0);
    assign pat_last   = pat_valid & w_final_pat;

endmodule
